// File: rtl/imem_dmem_arbiter.sv
// Purpose : shares one single-ported memory between instruction fetch (IF) and load/store (LS).
// Latency : grant in IDLE, memory request the next cycle, response passes straight through (>=3 cycles/txn).
// Backpress: one transaction outstanding; rdy only in IDLE; REQ holds until i_mem_req_rdy, RSP until i_mem_rsp_vld.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   i_if_req_vld/i_if_addr      fetch request; o_if_rdy accepts it
//   o_if_rsp_vld/o_if_rsp_data  fetch read data (suppressed after a flush)
//   i_ls_req_vld/i_ls_addr/i_ls_we/i_ls_wdata/i_ls_wstrb   load/store request; o_ls_rdy accepts it
//   o_ls_rsp_vld/o_ls_rsp_data  load data or store ack (data 0 for a store)
//   i_flush                     kills an in-flight fetch
//   o_mem_*/i_mem_req_rdy       memory request channel
//   i_mem_rsp_vld/i_mem_rsp_data memory response channel
module imem_dmem_arbiter #(
    parameter int MAX_LS_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_if_req_vld,
    input  logic [31:0] i_if_addr,
    output logic        o_if_rdy,
    output logic        o_if_rsp_vld,
    output logic [31:0] o_if_rsp_data,
    input  logic        i_ls_req_vld,
    input  logic [31:0] i_ls_addr,
    input  logic        i_ls_we,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_wstrb,
    output logic        o_ls_rdy,
    output logic        o_ls_rsp_vld,
    output logic [31:0] o_ls_rsp_data,
    input  logic        i_flush,
    output logic        o_mem_req_vld,
    input  logic        i_mem_req_rdy,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_rsp_vld,
    input  logic [31:0] i_mem_rsp_data
);

    localparam int SW = $clog2(MAX_LS_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);
    localparam logic OWN_LS = 1'b0;
    localparam logic OWN_IF = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t        state;
    logic          owner;
    logic          drop;
    logic [SW-1:0] streak;

    logic if_ok;
    logic streak_full;
    logic grant_if;
    logic grant_ls;
    logic rsp_fire;
    logic if_rsp_fire;
    logic ls_rsp_fire;

    // A fetch presented together with a flush is already stale, so it is not eligible.
    assign if_ok       = i_if_req_vld & ~i_flush;
    assign streak_full = (streak == STREAK_MAX);

    // Grants are gated by rst_n so nothing is accepted while the state cannot advance.
    assign grant_if = rst_n & (state == IDLE) & if_ok & (~i_ls_req_vld | streak_full);
    assign grant_ls = rst_n & (state == IDLE) & i_ls_req_vld & ~(if_ok & streak_full);

    assign o_if_rdy      = grant_if;
    assign o_ls_rdy      = grant_ls;
    assign o_mem_req_vld = (state == REQ);

    // A flush arriving in the same cycle as the response still kills it.
    assign rsp_fire    = (state == RSP) & i_mem_rsp_vld;
    assign if_rsp_fire = rsp_fire & (owner == OWN_IF) & ~drop & ~i_flush;
    assign ls_rsp_fire = rsp_fire & (owner == OWN_LS);

    assign o_if_rsp_vld  = if_rsp_fire;
    assign o_if_rsp_data = if_rsp_fire ? i_mem_rsp_data : 32'h0;
    assign o_ls_rsp_vld  = ls_rsp_fire;
    assign o_ls_rsp_data = (ls_rsp_fire & ~o_mem_we) ? i_mem_rsp_data : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= OWN_LS;
            drop        <= 1'b0;
            streak      <= '0;
            o_mem_addr  <= 32'h0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= 32'h0;
            o_mem_wstrb <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (grant_ls) begin
                        owner       <= OWN_LS;
                        o_mem_addr  <= i_ls_addr;
                        o_mem_we    <= i_ls_we;
                        o_mem_wdata <= i_ls_wdata;
                        o_mem_wstrb <= i_ls_wstrb;
                        state       <= REQ;
                        // Only count LS wins that actually made IF wait; saturate at the limit.
                        if (!i_if_req_vld) begin
                            streak <= '0;
                        end else if (!streak_full) begin
                            streak <= streak + SW'(1);
                        end
                    end else if (grant_if) begin
                        owner       <= OWN_IF;
                        o_mem_addr  <= i_if_addr;
                        o_mem_we    <= 1'b0;
                        o_mem_wdata <= 32'h0;
                        o_mem_wstrb <= 4'h0;
                        streak      <= '0;
                        state       <= REQ;
                    end else if (!i_if_req_vld) begin
                        streak <= '0;
                    end
                end
                REQ: begin
                    if (owner == OWN_IF && i_flush) begin
                        drop <= 1'b1;
                    end
                    if (i_mem_req_rdy) begin
                        state <= RSP;
                    end
                end
                RSP: begin
                    if (owner == OWN_IF && i_flush) begin
                        drop <= 1'b1;
                    end
                    if (i_mem_rsp_vld) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Purpose : directed self-checking bench for imem_dmem_arbiter.
// Latency : inputs driven 1 ns after the rising edge, outputs sampled 1 ns later.
// Backpress: the bench plays the memory, holding off request-ready and response as each scenario needs.
module tb_imem_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_if_req_vld;
    logic [31:0] i_if_addr;
    logic        o_if_rdy;
    logic        o_if_rsp_vld;
    logic [31:0] o_if_rsp_data;
    logic        i_ls_req_vld;
    logic [31:0] i_ls_addr;
    logic        i_ls_we;
    logic [31:0] i_ls_wdata;
    logic [3:0]  i_ls_wstrb;
    logic        o_ls_rdy;
    logic        o_ls_rsp_vld;
    logic [31:0] o_ls_rsp_data;
    logic        i_flush;
    logic        o_mem_req_vld;
    logic        i_mem_req_rdy;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_rsp_vld;
    logic [31:0] i_mem_rsp_data;

    int n_cmp;
    int n_err;

    imem_dmem_arbiter #(.MAX_LS_STREAK(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_if_req_vld   (i_if_req_vld),
        .i_if_addr      (i_if_addr),
        .o_if_rdy       (o_if_rdy),
        .o_if_rsp_vld   (o_if_rsp_vld),
        .o_if_rsp_data  (o_if_rsp_data),
        .i_ls_req_vld   (i_ls_req_vld),
        .i_ls_addr      (i_ls_addr),
        .i_ls_we        (i_ls_we),
        .i_ls_wdata     (i_ls_wdata),
        .i_ls_wstrb     (i_ls_wstrb),
        .o_ls_rdy       (o_ls_rdy),
        .o_ls_rsp_vld   (o_ls_rsp_vld),
        .o_ls_rsp_data  (o_ls_rsp_data),
        .i_flush        (i_flush),
        .o_mem_req_vld  (o_mem_req_vld),
        .i_mem_req_rdy  (i_mem_req_rdy),
        .o_mem_addr     (o_mem_addr),
        .o_mem_we       (o_mem_we),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_wstrb    (o_mem_wstrb),
        .i_mem_rsp_vld  (i_mem_rsp_vld),
        .i_mem_rsp_data (i_mem_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".if_rdy"},    {31'h0, o_if_rdy},      32'h0);
        check({tag, ".ls_rdy"},    {31'h0, o_ls_rdy},      32'h0);
        check({tag, ".if_rsp"},    {31'h0, o_if_rsp_vld},  32'h0);
        check({tag, ".ls_rsp"},    {31'h0, o_ls_rsp_vld},  32'h0);
        check({tag, ".if_data"},   o_if_rsp_data,          32'h0);
        check({tag, ".ls_data"},   o_ls_rsp_data,          32'h0);
        check({tag, ".mem_vld"},   {31'h0, o_mem_req_vld}, 32'h0);
        check({tag, ".mem_addr"},  o_mem_addr,             32'h0);
        check({tag, ".mem_we"},    {31'h0, o_mem_we},      32'h0);
        check({tag, ".mem_wdata"}, o_mem_wdata,            32'h0);
        check({tag, ".mem_wstrb"}, {28'h0, o_mem_wstrb},   32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n          = 1'b0;
        i_if_req_vld   = 1'b0;
        i_if_addr      = 32'h0;
        i_ls_req_vld   = 1'b0;
        i_ls_addr      = 32'h0;
        i_ls_we        = 1'b0;
        i_ls_wdata     = 32'h0;
        i_ls_wstrb     = 4'h0;
        i_flush        = 1'b0;
        i_mem_req_rdy  = 1'b0;
        i_mem_rsp_vld  = 1'b0;
        i_mem_rsp_data = 32'h0;

        // Reset state
        tick();
        tick();
        settle();
        check_all_zero("reset");
        rst_n = 1'b1;

        // 1. IF only, memory ready immediately, response two cycles after the request
        tick();
        i_if_req_vld  = 1'b1;
        i_if_addr     = 32'h0000_0000;
        i_mem_req_rdy = 1'b1;
        settle();
        check("t1.T0.if_rdy", {31'h0, o_if_rdy}, 32'h1);
        check("t1.T0.ls_rdy", {31'h0, o_ls_rdy}, 32'h0);
        tick();
        i_if_req_vld = 1'b0;
        settle();
        check("t1.T1.mem_vld",  {31'h0, o_mem_req_vld}, 32'h1);
        check("t1.T1.mem_addr", o_mem_addr,             32'h0);
        check("t1.T1.mem_we",   {31'h0, o_mem_we},      32'h0);
        check("t1.T1.if_rdy",   {31'h0, o_if_rdy},      32'h0);
        tick();
        settle();
        check("t1.T2.mem_vld", {31'h0, o_mem_req_vld}, 32'h0);
        check("t1.T2.if_rsp",  {31'h0, o_if_rsp_vld},  32'h0);
        tick();
        i_mem_rsp_vld  = 1'b1;
        i_mem_rsp_data = 32'h0000_0013;
        settle();
        check("t1.T3.if_rsp",  {31'h0, o_if_rsp_vld}, 32'h1);
        check("t1.T3.if_data", o_if_rsp_data,         32'h0000_0013);
        check("t1.T3.ls_rsp",  {31'h0, o_ls_rsp_vld}, 32'h0);
        tick();
        i_mem_rsp_vld = 1'b0;
        settle();
        check("t1.T4.if_rsp", {31'h0, o_if_rsp_vld}, 32'h0);

        // 2. Both valid every cycle: LS,LS,LS,LS,IF repeating; 3 cycles per transaction
        i_if_req_vld   = 1'b1;
        i_if_addr      = 32'h0000_0400;
        i_ls_req_vld   = 1'b1;
        i_ls_addr      = 32'h0000_0800;
        i_ls_we        = 1'b0;
        i_mem_req_rdy  = 1'b1;
        i_mem_rsp_vld  = 1'b1;
        i_mem_rsp_data = 32'h0000_0055;
        settle();
        for (int n = 0; n < 10; n++) begin
            logic exp_if;
            exp_if = ((n % 5) == 4);
            check($sformatf("t2.g%0d.if_rdy", n), {31'h0, o_if_rdy}, {31'h0, exp_if});
            check($sformatf("t2.g%0d.ls_rdy", n), {31'h0, o_ls_rdy}, {31'h0, ~exp_if});
            tick();
            settle();
            check($sformatf("t2.g%0d.addr", n), o_mem_addr, exp_if ? 32'h0000_0400 : 32'h0000_0800);
            tick();
            settle();
            check($sformatf("t2.g%0d.if_rsp", n), {31'h0, o_if_rsp_vld}, {31'h0, exp_if});
            check($sformatf("t2.g%0d.ls_rsp", n), {31'h0, o_ls_rsp_vld}, {31'h0, ~exp_if});
            tick();
            settle();
        end
        i_if_req_vld  = 1'b0;
        i_ls_req_vld  = 1'b0;
        i_mem_rsp_vld = 1'b0;

        // 3. LS store with memory stalling the request for 3 cycles
        i_ls_req_vld  = 1'b1;
        i_ls_we       = 1'b1;
        i_ls_addr     = 32'h0000_0100;
        i_ls_wdata    = 32'hDEAD_BEEF;
        i_ls_wstrb    = 4'h3;
        i_mem_req_rdy = 1'b0;
        settle();
        check("t3.ls_rdy", {31'h0, o_ls_rdy}, 32'h1);
        tick();
        i_ls_req_vld = 1'b0;
        i_ls_wdata   = 32'h1111_2222;
        i_ls_addr    = 32'h0000_0FFC;
        i_ls_wstrb   = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) i_mem_req_rdy = 1'b1;
            settle();
            check($sformatf("t3.c%0d.mem_vld", c),   {31'h0, o_mem_req_vld}, 32'h1);
            check($sformatf("t3.c%0d.mem_addr", c),  o_mem_addr,             32'h0000_0100);
            check($sformatf("t3.c%0d.mem_wdata", c), o_mem_wdata,            32'hDEAD_BEEF);
            check($sformatf("t3.c%0d.mem_wstrb", c), {28'h0, o_mem_wstrb},   32'h3);
            check($sformatf("t3.c%0d.mem_we", c),    {31'h0, o_mem_we},      32'h1);
            check($sformatf("t3.c%0d.ls_rdy", c),    {31'h0, o_ls_rdy},      32'h0);
            tick();
        end
        settle();
        check("t3.rsp.mem_vld", {31'h0, o_mem_req_vld}, 32'h0);
        tick();
        i_mem_rsp_vld  = 1'b1;
        i_mem_rsp_data = 32'h1234_5678;
        settle();
        check("t3.ls_rsp",  {31'h0, o_ls_rsp_vld}, 32'h1);
        check("t3.ls_data", o_ls_rsp_data,         32'h0);
        check("t3.if_rsp",  {31'h0, o_if_rsp_vld}, 32'h0);
        tick();
        i_mem_rsp_vld = 1'b0;
        i_ls_we       = 1'b0;

        // 4. Flush while a fetch is in RSP: response consumed silently
        i_if_req_vld = 1'b1;
        i_if_addr    = 32'h0000_0040;
        settle();
        check("t4.if_rdy", {31'h0, o_if_rdy}, 32'h1);
        tick();
        i_if_req_vld = 1'b0;
        tick();
        i_flush = 1'b1;
        settle();
        check("t4.flush.if_rsp", {31'h0, o_if_rsp_vld}, 32'h0);
        tick();
        i_flush        = 1'b0;
        i_mem_rsp_vld  = 1'b1;
        i_mem_rsp_data = 32'h0000_00AA;
        settle();
        check("t4.drop.if_rsp",  {31'h0, o_if_rsp_vld}, 32'h0);
        check("t4.drop.if_data", o_if_rsp_data,         32'h0);
        check("t4.drop.ls_rsp",  {31'h0, o_ls_rsp_vld}, 32'h0);
        tick();
        i_mem_rsp_vld = 1'b0;
        // Flush in IDLE blocks the fetch grant that cycle
        i_if_req_vld = 1'b1;
        i_if_addr    = 32'h0000_0044;
        i_flush      = 1'b1;
        settle();
        check("t4.idle_flush.if_rdy", {31'h0, o_if_rdy}, 32'h0);
        tick();
        i_flush = 1'b0;
        settle();
        check("t4.next.if_rdy", {31'h0, o_if_rdy}, 32'h1);
        tick();
        i_if_req_vld = 1'b0;
        settle();
        check("t4.next.mem_addr", o_mem_addr, 32'h0000_0044);
        tick();
        tick();
        i_mem_rsp_vld  = 1'b1;
        i_mem_rsp_data = 32'h0000_0077;
        settle();
        check("t4.next.if_rsp",  {31'h0, o_if_rsp_vld}, 32'h1);
        check("t4.next.if_data", o_if_rsp_data,         32'h0000_0077);
        tick();
        i_mem_rsp_vld = 1'b0;

        // 5. Reset during REQ, then a stray response in IDLE
        i_ls_req_vld  = 1'b1;
        i_ls_addr     = 32'h0000_0200;
        i_ls_we       = 1'b1;
        i_ls_wdata    = 32'hCAFE_F00D;
        i_ls_wstrb    = 4'hF;
        i_mem_req_rdy = 1'b0;
        settle();
        check("t5.ls_rdy", {31'h0, o_ls_rdy}, 32'h1);
        tick();
        i_ls_req_vld = 1'b0;
        settle();
        check("t5.req.mem_vld", {31'h0, o_mem_req_vld}, 32'h1);
        rst_n = 1'b0;
        tick();
        settle();
        check_all_zero("t5.after_rst");
        rst_n          = 1'b1;
        i_mem_rsp_vld  = 1'b1;
        i_mem_rsp_data = 32'h0000_0099;
        tick();
        settle();
        check("t5.stray.if_rsp",  {31'h0, o_if_rsp_vld},  32'h0);
        check("t5.stray.ls_rsp",  {31'h0, o_ls_rsp_vld},  32'h0);
        check("t5.stray.ls_data", o_ls_rsp_data,          32'h0);
        check("t5.stray.mem_vld", {31'h0, o_mem_req_vld}, 32'h0);
        i_mem_rsp_vld = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
